// File: rtl/sync_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_frame_tx : "110" sync preamble + MSB-first payload, each 1 stuffed 0   |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module sync_frame_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              ser_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int               IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC1 = 3'd1,
        SYNC2 = 3'd2,
        SEP   = 3'd3,
        DATA  = 3'd4,
        STUFF = 3'd5
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [IDX_W-1:0]  idx_q;
    logic              ser_q;
    logic              done_q;
    logic              ready_q;
    logic [DATA_W-1:0] w_shift_nxt;

    // The current payload bit always sits in shift_q's MSB; idx_q counts bits left.
    assign w_shift_nxt = shift_q << 1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ser_q <= 1'b0;
                    if (tx_valid) begin
                        state_q <= SYNC1;
                        ser_q   <= 1'b1;
                        ready_q <= 1'b0;
                        shift_q <= tx_data;
                    end
                end
                SYNC1: begin
                    state_q <= SYNC2;
                    ser_q   <= 1'b1;
                end
                SYNC2: begin
                    state_q <= SEP;
                    ser_q   <= 1'b0;
                end
                SEP: begin
                    state_q <= DATA;
                    idx_q   <= IDX_MSB;
                    ser_q   <= shift_q[DATA_W-1];
                    done_q  <= (IDX_MSB == '0) && !shift_q[DATA_W-1];
                end
                DATA: begin
                    shift_q <= w_shift_nxt;
                    if (shift_q[DATA_W-1]) begin
                        state_q <= STUFF;
                        ser_q   <= 1'b0;
                        done_q  <= (idx_q == '0);
                    end else if (idx_q != '0) begin
                        state_q <= DATA;
                        idx_q   <= idx_q - IDX_ONE;
                        ser_q   <= w_shift_nxt[DATA_W-1];
                        done_q  <= (idx_q == IDX_ONE) && !w_shift_nxt[DATA_W-1];
                    end else begin
                        state_q <= IDLE;
                        ser_q   <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                STUFF: begin
                    if (idx_q == '0) begin
                        state_q <= IDLE;
                        ser_q   <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= DATA;
                        idx_q   <= idx_q - IDX_ONE;
                        ser_q   <= shift_q[DATA_W-1];
                        done_q  <= (idx_q == IDX_ONE) && !shift_q[DATA_W-1];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ser_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready   = ready_q;
    assign busy       = ~ready_q;
    assign ser_out    = ser_q;
    assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sync_frame_tx : directed vector table plus corner sequences and random   |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_sync_frame_tx;

    logic       clk;
    logic       reset_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       ser_out;
    logic       busy;
    logic       frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    sync_frame_tx #(.DATA_W(8)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .ser_out    (ser_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        int          len;
        logic [31:0] ser;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Samples n frame bits (first bit is the current cycle), oldest bit ends up most significant.
    task automatic capture(input int n, output logic [31:0] s, output logic [31:0] d,
                           output logic rdy_bad);
        s = '0;
        d = '0;
        rdy_bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = {s[30:0], ser_out};
            d = {d[30:0], frame_done};
            if (tx_ready !== 1'b0 || busy !== 1'b1) rdy_bad = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    vec_t        tbl[6];
    logic [31:0] s, d;
    logic        rb;
    int          errs;
    logic [7:0]  p, rx;
    bit          bits[$];
    int          len, pos;
    bit          fin, bad11, badstuff;

    initial begin
        tbl[0] = '{8'h00, 11, 32'h00000600};
        tbl[1] = '{8'hFF, 19, 32'h0006AAAA};
        tbl[2] = '{8'h01, 12, 32'h00000C02};
        tbl[3] = '{8'h80, 12, 32'h00000D00};
        tbl[4] = '{8'h5A, 15, 32'h000064A4};
        tbl[5] = '{8'hC3, 15, 32'h00006A0A};

        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {28'd0, ser_out, tx_ready, busy, frame_done}, 32'h4);

        // Handshake on the very first edge after reset release.
        @(negedge clk);
        reset_n  = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        capture(15, s, d, rb);
        check("A5_ser", s, 32'h00006912);
        check("A5_done", d, 32'h1);
        check("A5_ready", {31'd0, rb}, 32'h0);
        check("A5_idle", {29'd0, ser_out, tx_ready, frame_done}, 32'h2);

        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = tbl[v].data;
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            tx_data  = ~tbl[v].data;
            capture(tbl[v].len, s, d, rb);
            check($sformatf("vec%0d_ser", v), s, tbl[v].ser);
            check($sformatf("vec%0d_done", v), d, 32'h1);
            check($sformatf("vec%0d_ready", v), {31'd0, rb}, 32'h0);
            check($sformatf("vec%0d_idle", v), {29'd0, ser_out, tx_ready, frame_done}, 32'h2);
        end

        // Abort C3 while in DATA bit 4 (ninth frame cycle).
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort_pre_busy", {31'd0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("abort_now", {28'd0, ser_out, tx_ready, busy, frame_done}, 32'h4);
        @(negedge clk);
        reset_n = 1'b1;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (ser_out !== 1'b0 || frame_done !== 1'b0 || tx_ready !== 1'b1) errs++;
        end
        check("abort_quiet", errs, 0);

        // Back-to-back with tx_valid held high.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h81;
        @(posedge clk);
        #1;
        tx_data = 8'h7E;
        capture(13, s, d, rb);
        check("b2b_81_ser", s, 32'h00001A02);
        check("b2b_81_done", d, 32'h1);
        check("b2b_gap", {30'd0, ser_out, tx_ready}, 32'h1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        capture(17, s, d, rb);
        check("b2b_7E_ser", s, 32'h00019554);
        check("b2b_7E_done", d, 32'h1);
        check("b2b_7E_ready", {31'd0, rb}, 32'h0);
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            if (ser_out !== 1'b0 || tx_ready !== 1'b1) errs++;
            @(posedge clk);
            #1;
        end
        check("b2b_no_extra", errs, 0);

        // Random payloads: deserialize and verify framing independently of the DUT.
        for (int k = 0; k < 20; k++) begin
            p = 8'($urandom);
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = p;
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            bits.delete();
            len = 0;
            fin = 1'b0;
            while (!fin && len < 40) begin
                bits.push_back(ser_out);
                fin = frame_done;
                len++;
                @(posedge clk);
                #1;
            end
            check($sformatf("rnd%0d_done_seen", k), {31'd0, fin}, 32'h1);
            check($sformatf("rnd%0d_len", k), len, 11 + $countones(p));
            bad11 = 1'b0;
            for (int i = 2; i < len; i++)
                if (bits[i-1] && bits[i]) bad11 = 1'b1;
            if (len > 0 && bits[len-1] && ser_out) bad11 = 1'b1;
            check($sformatf("rnd%0d_no11", k), {31'd0, bad11}, 32'h0);
            rx = '0;
            badstuff = 1'b0;
            if (len < 3 || !bits[0] || !bits[1] || bits[2]) badstuff = 1'b1;
            pos = 3;
            for (int b = 7; b >= 0; b--) begin
                if (pos < len) begin
                    rx[b] = bits[pos];
                    pos++;
                    if (rx[b]) begin
                        if (pos >= len || bits[pos]) badstuff = 1'b1;
                        pos++;
                    end
                end else begin
                    badstuff = 1'b1;
                end
            end
            check($sformatf("rnd%0d_payload", k), {23'd0, badstuff, rx}, {24'd0, p});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_frame_tx.md
SYNC_FRAME_TX -- requirements
Module: sync_frame_tx

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the payload width in bits (legal range 1..32).
REQ-002 The module SHALL have port clk, input, 1 bit: clock; all logic is rising-edge triggered.
REQ-003 The module SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port tx_valid, input, 1 bit: the payload on tx_data is offered.
REQ-005 The module SHALL have port tx_data, input, DATA_W bits: the payload, transmitted MSB first.
REQ-006 The module SHALL have port tx_ready, output, 1 bit: the module accepts a payload this cycle.
REQ-007 The module SHALL have port ser_out, output, 1 bit: the registered serial line.
REQ-008 The module SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-009 The module SHALL have port frame_done, output, 1 bit: a one-cycle pulse coincident with the final frame bit.

Function
REQ-010 A handshake SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; tx_data SHALL be captured into an internal shift register at that edge.
REQ-011 Changes on tx_data or tx_valid after the handshake SHALL have no effect on the frame in progress.
REQ-012 tx_ready SHALL be 1 only in state IDLE; it SHALL be a function of state only, not of tx_valid.
REQ-013 busy SHALL equal NOT tx_ready.
REQ-014 The state machine SHALL have states IDLE, SYNC1, SYNC2, SEP, DATA and STUFF; ser_out SHALL be registered from the state being entered.
REQ-015 IDLE: ser_out=0; on handshake the next state SHALL be SYNC1, otherwise IDLE.
REQ-016 SYNC1: ser_out=1; the next state SHALL be SYNC2.
REQ-017 SYNC2: ser_out=1; the next state SHALL be SEP.
REQ-018 SEP: ser_out=0; the next state SHALL be DATA with the bit index at DATA_W-1.
REQ-019 DATA: ser_out SHALL equal the current payload bit.
REQ-020 From DATA, when the current bit is 1, the next state SHALL be STUFF.
REQ-021 From DATA, when the current bit is 0 and it is not the last bit, the next state SHALL be DATA with the bit index decremented.
REQ-022 From DATA, when the current bit is 0 and it is the last bit, the next state SHALL be IDLE.
REQ-023 STUFF: ser_out=0; the next state SHALL be DATA with the next bit index, or IDLE if the stuffed bit followed the last payload bit.
REQ-024 The first sync bit SHALL appear on ser_out in the cycle after the handshake edge, giving a latency of 1 cycle.
REQ-025 Frame length SHALL be 3 + DATA_W + popcount(tx_data) cycles, counted from the first SYNC1 bit through the final bit inclusive.
REQ-026 Consequence: outside SYNC1/SYNC2, ser_out SHALL never contain two consecutive 1s, including across frame boundaries; the run "11" marks a frame start only.
REQ-027 frame_done SHALL be 1 exactly in the cycle ser_out carries the final frame bit: the last payload bit if it is 0, otherwise its stuff bit.
REQ-028 At least one IDLE cycle (ser_out=0, tx_ready=1) SHALL separate consecutive frames; a handshake SHALL be possible in that first IDLE cycle.
REQ-029 A bit index counter SHALL be sized ceil(log2(DATA_W)) bits minimum, and SHALL NOT wrap within a frame.
REQ-030 Illegal or unused state encodings SHALL transition to IDLE with ser_out=0.

Reset
REQ-031 While reset_n=0, asynchronously: state=IDLE, ser_out=0, frame_done=0, busy=0, tx_ready=1, and the shift register SHALL be cleared.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately; after release no residual bits SHALL be emitted and frame_done SHALL NOT pulse.
REQ-033 The first handshake SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-034 DATA_W=8, tx_data=8'hA5, single handshake -> ser_out = 1,1,0 then 1,0,0,1,0,0,0,1,0,0,1,0 (15 cycles), with frame_done on the 15th bit.
REQ-035 tx_data=8'h00 -> ser_out = 1,1,0,0,0,0,0,0,0,0,0 (11 cycles), with frame_done on the 11th bit.
REQ-036 tx_data=8'hFF -> ser_out = 1,1,0 then (1,0) repeated 8 times (19 cycles), with tx_ready=0 throughout and frame_done on the final 0.
REQ-037 tx_valid held high with 8'h81 then 8'h7E -> the second is accepted in the IDLE cycle after frame_done, exactly one 0 separates the frames, and no extra handshake occurs.
REQ-038 Reset pulsed during the DATA bit 4 of 8'hC3 -> ser_out=0 and tx_ready=1 immediately; with tx_valid=0 after release, ser_out stays 0 and frame_done stays 0.
REQ-039 Randomized payloads -> a checker SHALL flag "11" outside SYNC1/SYNC2, frame length mismatch, or a deserialized payload mismatch.
